// File: rtl/sia_rx_queue_if.sv
// Host-side bus of the SIA receive queue: pop/output-enable requests and head/flag status.
// The master modport is the host; the slave modport is the queue.
interface sia_rx_queue_if #(
    parameter int DATA_BITS = 12
);
    logic                 rxq_pop_i;
    logic                 rxq_oe_i;
    logic [DATA_BITS-1:0] rxq_dat_o;
    logic                 rxq_full_o;
    logic                 rxq_not_empty_o;

    modport master (
        output rxq_pop_i,
        output rxq_oe_i,
        input  rxq_dat_o,
        input  rxq_full_o,
        input  rxq_not_empty_o
    );

    modport slave (
        input  rxq_pop_i,
        input  rxq_oe_i,
        output rxq_dat_o,
        output rxq_full_o,
        output rxq_not_empty_o
    );
endinterface

// File: rtl/sia_rx_queue.sv
// SIA receive path: oversampling async deserialiser feeding a small receive queue.
// Optional feature macro SIA_RXQ_OVERRUN_EN adds rxq_overrun_o (sticky dropped-frame flag).
module sia_rx_queue #(
    parameter int SHIFT_REG_WIDTH = 12,
    parameter int BAUD_RATE_WIDTH = 32,
    parameter int DEPTH_BITS      = 2,
    parameter int DATA_BITS       = 12
) (
    input  logic                       clk_i,
    input  logic                       reset_i,
    input  logic [4:0]                 bits_i,
    input  logic [BAUD_RATE_WIDTH-1:0] baud_i,
    input  logic                       eedd_i,
    input  logic                       eedc_i,
    input  logic                       rxd_i,
    input  logic                       rxc_i,
    sia_rx_queue_if.slave              rxq
`ifdef SIA_RXQ_OVERRUN_EN
    ,
    output logic                       rxq_overrun_o
`endif
);
    localparam int DEPTH = 1 << DEPTH_BITS;
    localparam logic [DEPTH_BITS:0] FULL_COUNT = (DEPTH_BITS + 1)'(DEPTH);

    typedef enum logic {IDLE, SAMPLE} state_t;

    state_t                     state_q, state_d;
    logic [BAUD_RATE_WIDTH-1:0] baud_cnt_q, baud_cnt_d;
    logic [4:0]                 bit_cnt_q, bit_cnt_d;
    logic [SHIFT_REG_WIDTH-1:0] shift_q, shift_d;
    logic                       rxd_meta_q, rxd_sync_q, rxd_prev_q;
    logic                       rxc_meta_q, rxc_sync_q, rxc_prev_q;
    logic [DEPTH_BITS-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [DEPTH_BITS:0]        count_q, count_d;
    logic                       overrun_q, overrun_d;

    logic [DATA_BITS-1:0]       mem [DEPTH];

    logic [BAUD_RATE_WIDTH:0]   period_ext, half_ext;
    logic [BAUD_RATE_WIDTH-1:0] half_load;
    logic [SHIFT_REG_WIDTH-1:0] shifted;
    logic                       bits_ok, push, push_ok, pop_ok, full;

    // Counter counts down to zero inclusive, so load one less than the wanted interval.
    assign period_ext = {1'b0, baud_i} + (BAUD_RATE_WIDTH + 1)'(1);
    assign half_ext   = period_ext >> 1;
    assign half_load  = (half_ext == '0) ? '0
                      : half_ext[BAUD_RATE_WIDTH-1:0] - BAUD_RATE_WIDTH'(1);
    assign shifted    = {rxd_sync_q, shift_q[SHIFT_REG_WIDTH-1:1]};
    assign bits_ok    = (bits_i != 5'd0) && (int'(bits_i) <= SHIFT_REG_WIDTH);
    assign full       = (count_q == FULL_COUNT);

    always_comb begin
        state_d    = state_q;
        baud_cnt_d = baud_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        push       = 1'b0;
        case (state_q)
            IDLE: begin
                if (eedd_i && bits_ok && rxd_prev_q && !rxd_sync_q) begin
                    baud_cnt_d = half_load;
                    bit_cnt_d  = 5'd0;
                    state_d    = SAMPLE;
                end
            end
            SAMPLE: begin
                if (baud_cnt_q == '0) begin
                    shift_d    = shifted;
                    baud_cnt_d = baud_i;
                    bit_cnt_d  = bit_cnt_q + 5'd1;
                    if (bit_cnt_q == 5'd0 && rxd_sync_q) begin
                        shift_d = '1;
                        state_d = IDLE;
                    end else if (bit_cnt_q + 5'd1 >= bits_i) begin
                        // >= so a frame length lowered mid-frame still terminates
                        push    = 1'b1;
                        shift_d = '1;
                        state_d = IDLE;
                    end
                end else if (eedc_i && rxc_sync_q && !rxc_prev_q) begin
                    baud_cnt_d = half_load;
                end else begin
                    baud_cnt_d = baud_cnt_q - BAUD_RATE_WIDTH'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        push_ok   = push && !full;
        pop_ok    = rxq.rxq_pop_i && (count_q != '0);
        wr_ptr_d  = push_ok ? wr_ptr_q + DEPTH_BITS'(1) : wr_ptr_q;
        rd_ptr_d  = pop_ok  ? rd_ptr_q + DEPTH_BITS'(1) : rd_ptr_q;
        count_d   = count_q;
        if (push_ok && !pop_ok) count_d = count_q + (DEPTH_BITS + 1)'(1);
        if (pop_ok && !push_ok) count_d = count_q - (DEPTH_BITS + 1)'(1);
        overrun_d = overrun_q;
        if (rxq.rxq_pop_i) overrun_d = 1'b0;
        if (push && full)  overrun_d = 1'b1;
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            state_q    <= IDLE;
            baud_cnt_q <= '0;
            bit_cnt_q  <= '0;
            shift_q    <= '1;
            rxd_meta_q <= 1'b1;
            rxd_sync_q <= 1'b1;
            rxd_prev_q <= 1'b1;
            rxc_meta_q <= 1'b0;
            rxc_sync_q <= 1'b0;
            rxc_prev_q <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overrun_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            baud_cnt_q <= baud_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            rxd_meta_q <= rxd_i;
            rxd_sync_q <= rxd_meta_q;
            rxd_prev_q <= rxd_sync_q;
            rxc_meta_q <= rxc_i;
            rxc_sync_q <= rxc_meta_q;
            rxc_prev_q <= rxc_sync_q;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overrun_q  <= overrun_d;
        end
    end

    // Storage carries no reset so it can map onto distributed RAM.
    always_ff @(posedge clk_i) begin
        if (push_ok) mem[wr_ptr_q] <= shifted[SHIFT_REG_WIDTH-1 -: DATA_BITS];
    end

    assign rxq.rxq_dat_o       = rxq.rxq_oe_i ? mem[rd_ptr_q] : '0;
    assign rxq.rxq_full_o      = full;
    assign rxq.rxq_not_empty_o = (count_q != '0);

`ifdef SIA_RXQ_OVERRUN_EN
    assign rxq_overrun_o = overrun_q;
`else
    logic unused_overrun;
    assign unused_overrun = overrun_q;
`endif
endmodule

// File: tb/tb_sia_rx_queue.sv
// Directed bench for sia_rx_queue: 8N1 frames at 1 Mbps from a 50 MHz clock, queue fill/drain,
// drop on full, false start, illegal frame lengths and mid-frame reset.
module tb_sia_rx_queue;
    localparam int BIT_NS = 1000;
    localparam logic [11:0] W85 = 12'b1_10000101_0_11;
    localparam logic [11:0] WA1 = 12'b1_10100001_0_11;

    logic        clk_i = 1'b0;
    logic        reset_i = 1'b0;
    logic [4:0]  bits_i = 5'd10;
    logic [31:0] baud_i = 32'd49;
    logic        eedd_i = 1'b1;
    logic        eedc_i = 1'b0;
    logic        rxd_i = 1'b1;
    logic        rxc_i = 1'b0;
`ifdef SIA_RXQ_OVERRUN_EN
    logic        rxq_overrun_o;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    sia_rx_queue_if #(.DATA_BITS(12)) rxq_bus ();

    sia_rx_queue dut (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .bits_i  (bits_i),
        .baud_i  (baud_i),
        .eedd_i  (eedd_i),
        .eedc_i  (eedc_i),
        .rxd_i   (rxd_i),
        .rxc_i   (rxc_i),
        .rxq     (rxq_bus)
`ifdef SIA_RXQ_OVERRUN_EN
        ,
        .rxq_overrun_o (rxq_overrun_o)
`endif
    );

    always #10 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
            $display("check %-14s got=0x%0h exp=0x%0h ok", tag, got, exp);
        end else begin
            $display("FAIL %-14s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic send_frame(input logic [7:0] data);
        rxd_i = 1'b0;
        #(BIT_NS);
        for (int i = 0; i < 8; i++) begin
            rxd_i = data[i];
            #(BIT_NS);
        end
        rxd_i = 1'b1;
        #(BIT_NS);
        #(2 * BIT_NS);
    endtask

    task automatic pop_once();
        @(negedge clk_i);
        rxq_bus.rxq_pop_i = 1'b1;
        @(negedge clk_i);
        rxq_bus.rxq_pop_i = 1'b0;
    endtask

    task automatic check_flags(input string tag, input logic ne, input logic fu);
        check({tag, ".ne"}, 32'(rxq_bus.rxq_not_empty_o), 32'(ne));
        check({tag, ".full"}, 32'(rxq_bus.rxq_full_o), 32'(fu));
    endtask

    initial begin
        rxq_bus.rxq_pop_i = 1'b0;
        rxq_bus.rxq_oe_i  = 1'b0;
        repeat (3) @(negedge clk_i);
        check_flags("reset", 1'b0, 1'b0);
        check("reset.dat", 32'(rxq_bus.rxq_dat_o), 32'h0);
        reset_i = 1'b1;

        for (int i = 0; i < 4; i++) begin
            pop_once();
            check("pop_empty.dat", 32'(rxq_bus.rxq_dat_o), 32'h0);
            check_flags("pop_empty", 1'b0, 1'b0);
        end

        #(2 * BIT_NS);
        send_frame(8'h85);
        check_flags("one", 1'b1, 1'b0);
        rxq_bus.rxq_oe_i = 1'b1;
        #1;
        check("one.dat", 32'(rxq_bus.rxq_dat_o), 32'(W85));

        send_frame(8'hA1);
        check_flags("two", 1'b1, 1'b0);
        send_frame(8'h85);
        send_frame(8'hA1);
        check_flags("four", 1'b1, 1'b1);
        check("four.dat", 32'(rxq_bus.rxq_dat_o), 32'(W85));
`ifdef SIA_RXQ_OVERRUN_EN
        check("ovr.before", 32'(rxq_overrun_o), 32'h0);
`endif

        send_frame(8'h3C);
        check_flags("drop", 1'b1, 1'b1);
        check("drop.dat", 32'(rxq_bus.rxq_dat_o), 32'(W85));
`ifdef SIA_RXQ_OVERRUN_EN
        check("ovr.set", 32'(rxq_overrun_o), 32'h1);
`endif

        pop_once();
        check("pop1.dat", 32'(rxq_bus.rxq_dat_o), 32'(WA1));
        check_flags("pop1", 1'b1, 1'b0);
`ifdef SIA_RXQ_OVERRUN_EN
        check("ovr.clear", 32'(rxq_overrun_o), 32'h0);
`endif
        pop_once();
        check("pop2.dat", 32'(rxq_bus.rxq_dat_o), 32'(W85));
        pop_once();
        check("pop3.dat", 32'(rxq_bus.rxq_dat_o), 32'(WA1));
        check_flags("pop3", 1'b1, 1'b0);
        pop_once();
        check("pop4.dat", 32'(rxq_bus.rxq_dat_o), 32'(W85));
        check_flags("pop4", 1'b0, 1'b0);
        pop_once();
        check("pop5.dat", 32'(rxq_bus.rxq_dat_o), 32'(W85));
        check_flags("pop5", 1'b0, 1'b0);

        // 200 ns low pulse: start sample lands after rxd has returned high
        rxd_i = 1'b0;
        #200;
        rxd_i = 1'b1;
        #(3 * BIT_NS);
        check_flags("glitch", 1'b0, 1'b0);

        for (int i = 0; i < 2; i++) begin
            bits_i = (i == 0) ? 5'd0 : 5'd13;
            send_frame(8'h85);
            check_flags("bad_bits", 1'b0, 1'b0);
        end
        bits_i = 5'd10;

        send_frame(8'hA1);
        check_flags("pre_rst", 1'b1, 1'b0);
        check("pre_rst.dat", 32'(rxq_bus.rxq_dat_o), 32'(WA1));

        rxd_i = 1'b0;
        #(BIT_NS);
        rxd_i = 1'b1;
        #(BIT_NS);
        rxd_i = 1'b0;
        #(BIT_NS / 2);
        reset_i = 1'b0;
        #100;
        check_flags("mid_rst", 1'b0, 1'b0);
        rxd_i = 1'b1;
        #100;
        reset_i = 1'b1;
        #(2 * BIT_NS);
        check_flags("post_rst", 1'b0, 1'b0);
        send_frame(8'h85);
        check_flags("after_rst", 1'b1, 1'b0);
        check("after_rst.dat", 32'(rxq_bus.rxq_dat_o), 32'(W85));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
